// File: rtl/dac_seq_pkg.sv
// Shared types for the SPGD DAC phase sequencer.
// State encoding and PHASE codes (PHASE uses the same codes as MAN_SEL).
package dac_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_P_SETTLE,
      S_P_SAMPLE,
      S_M_SETTLE,
      S_M_SAMPLE,
      S_RESTORE
   } state_t;

   localparam logic [1:0] PH_ZERO  = 2'b00;
   localparam logic [1:0] PH_PLUS  = 2'b01;
   localparam logic [1:0] PH_MINUS = 2'b10;
   localparam logic [1:0] PH_U     = 2'b11;

endpackage

// File: rtl/dac_sat_addsub.sv
// One channel of U+dU / U-dU, clamped to the unsigned DAC code range.
// Math is done at DATA_WIDTH+2 bits signed so neither result can wrap.
module dac_sat_addsub #(
   parameter int DATA_WIDTH = 14
) (
   input  logic [DATA_WIDTH-1:0] u,
   input  logic [DATA_WIDTH-1:0] du,
   output logic [DATA_WIDTH-1:0] p,
   output logic [DATA_WIDTH-1:0] m
);

   localparam int XW = DATA_WIDTH + 2;

   logic signed [XW-1:0] u_x;
   logic signed [XW-1:0] du_x;
   logic signed [XW-1:0] p_x;
   logic signed [XW-1:0] m_x;

   function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [XW-1:0] v);
      // sign bit -> below zero; bit DATA_WIDTH -> above full scale
      if (v[XW-1])
         return '0;
      else if (v[XW-2])
         return '1;
      else
         return v[DATA_WIDTH-1:0];
   endfunction

   assign u_x  = $signed({2'b00, u});
   assign du_x = $signed({{2{du[DATA_WIDTH-1]}}, du});
   assign p_x  = u_x + du_x;
   assign m_x  = u_x - du_x;
   assign p    = sat(p_x);
   assign m    = sat(m_x);

endmodule

// File: rtl/dac_phase_sequencer.sv
// N-channel DAC perturbation sequencer for the SPGD loop: manual select
// or auto +dU / -dU cycle with settle time and ADC sample handshakes.
module dac_phase_sequencer
   import dac_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 14,
   parameter int NUM_CH     = 2,
   parameter int SETTLE_W   = 16
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         MODE,
   input  logic [1:0]                   MAN_SEL,
   input  logic                         START,
   input  logic                         ABORT,
   input  logic [SETTLE_W-1:0]          SETTLE_CYCLES,
   input  logic [NUM_CH*DATA_WIDTH-1:0] U_BUS,
   input  logic [NUM_CH*DATA_WIDTH-1:0] DU_BUS,
   output logic [NUM_CH*DATA_WIDTH-1:0] DAC_OUT,
   output logic [1:0]                   PHASE,
   output logic                         SAMPLE_REQ,
   input  logic                         SAMPLE_ACK,
   output logic                         SAMPLE_TAG,
   output logic                         BUSY,
   output logic                         DONE
);

   localparam int BW = NUM_CH * DATA_WIDTH;

   state_t              state;
   logic [SETTLE_W-1:0] cnt;
   logic [BW-1:0]       lat_u;
   logic [BW-1:0]       lat_du;
   logic [BW-1:0]       live_p;
   logic [BW-1:0]       live_m;
   logic [BW-1:0]       lat_p;
   logic [BW-1:0]       lat_m;
   logic [BW-1:0]       man_val;
   logic                settle_last;

   // live pair feeds manual mode and the first P; latched pair the rest
   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      dac_sat_addsub #(.DATA_WIDTH(DATA_WIDTH)) u_live (
         .u  (U_BUS[k*DATA_WIDTH +: DATA_WIDTH]),
         .du (DU_BUS[k*DATA_WIDTH +: DATA_WIDTH]),
         .p  (live_p[k*DATA_WIDTH +: DATA_WIDTH]),
         .m  (live_m[k*DATA_WIDTH +: DATA_WIDTH])
      );
      dac_sat_addsub #(.DATA_WIDTH(DATA_WIDTH)) u_lat (
         .u  (lat_u[k*DATA_WIDTH +: DATA_WIDTH]),
         .du (lat_du[k*DATA_WIDTH +: DATA_WIDTH]),
         .p  (lat_p[k*DATA_WIDTH +: DATA_WIDTH]),
         .m  (lat_m[k*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   always_comb begin
      man_val = '0;
      case (MAN_SEL)
         PH_U:     man_val = U_BUS;
         PH_PLUS:  man_val = live_p;
         PH_MINUS: man_val = live_m;
         default:  man_val = '0;
      endcase
   end

   // a load of N gives N cycles in a settle state, minimum one
   assign settle_last = (cnt[SETTLE_W-1:1] == '0);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= S_IDLE;
         cnt        <= '0;
         lat_u      <= '0;
         lat_du     <= '0;
         DAC_OUT    <= '0;
         PHASE      <= PH_ZERO;
         SAMPLE_REQ <= 1'b0;
         SAMPLE_TAG <= 1'b0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
      end else begin
         DONE <= 1'b0;
         if (ABORT) begin
            state      <= S_IDLE;
            cnt        <= '0;
            DAC_OUT    <= '0;
            PHASE      <= PH_ZERO;
            SAMPLE_REQ <= 1'b0;
            SAMPLE_TAG <= 1'b0;
            BUSY       <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (!MODE) begin
                     DAC_OUT <= man_val;
                     PHASE   <= MAN_SEL;
                  end else if (START) begin
                     lat_u   <= U_BUS;
                     lat_du  <= DU_BUS;
                     DAC_OUT <= live_p;
                     PHASE   <= PH_PLUS;
                     cnt     <= SETTLE_CYCLES;
                     BUSY    <= 1'b1;
                     state   <= S_P_SETTLE;
                  end
               end
               S_P_SETTLE: begin
                  if (settle_last) begin
                     SAMPLE_REQ <= 1'b1;
                     SAMPLE_TAG <= 1'b1;
                     state      <= S_P_SAMPLE;
                  end else begin
                     cnt <= cnt - SETTLE_W'(1);
                  end
               end
               S_P_SAMPLE: begin
                  if (SAMPLE_ACK) begin
                     SAMPLE_REQ <= 1'b0;
                     SAMPLE_TAG <= 1'b0;
                     DAC_OUT    <= lat_m;
                     PHASE      <= PH_MINUS;
                     cnt        <= SETTLE_CYCLES;
                     state      <= S_M_SETTLE;
                  end
               end
               S_M_SETTLE: begin
                  if (settle_last) begin
                     SAMPLE_REQ <= 1'b1;
                     SAMPLE_TAG <= 1'b0;
                     state      <= S_M_SAMPLE;
                  end else begin
                     cnt <= cnt - SETTLE_W'(1);
                  end
               end
               S_M_SAMPLE: begin
                  if (SAMPLE_ACK) begin
                     SAMPLE_REQ <= 1'b0;
                     DAC_OUT    <= lat_u;
                     PHASE      <= PH_U;
                     DONE       <= 1'b1;
                     state      <= S_RESTORE;
                  end
               end
               S_RESTORE: begin
                  BUSY  <= 1'b0;
                  state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dac_phase_sequencer.sv
// Directed bench for dac_phase_sequencer: manual table, auto sequence,
// saturation, abort, zero settle / held ACK, reset mid-sequence.
module tb_dac_phase_sequencer;

   localparam int DW = 14;
   localparam int NC = 2;
   localparam int SW = 16;

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic             MODE = 1'b0;
   logic [1:0]       MAN_SEL = 2'b00;
   logic             START = 1'b0;
   logic             ABORT = 1'b0;
   logic [SW-1:0]    SETTLE_CYCLES = '0;
   logic [NC*DW-1:0] U_BUS = '0;
   logic [NC*DW-1:0] DU_BUS = '0;
   logic [NC*DW-1:0] DAC_OUT;
   logic [1:0]       PHASE;
   logic             SAMPLE_REQ;
   logic             SAMPLE_ACK = 1'b0;
   logic             SAMPLE_TAG;
   logic             BUSY;
   logic             DONE;

   logic [DW-1:0] dac0;
   logic [DW-1:0] dac1;

   int tests = 0;
   int failed = 0;
   int done_cnt = 0;

   typedef struct {
      logic [1:0] sel;
      int u0, du0, u1, du1;
      int e0, e1;
   } vec_t;

   vec_t vecs[$];

   dac_phase_sequencer #(.DATA_WIDTH(DW), .NUM_CH(NC), .SETTLE_W(SW)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .MODE          (MODE),
      .MAN_SEL       (MAN_SEL),
      .START         (START),
      .ABORT         (ABORT),
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .U_BUS         (U_BUS),
      .DU_BUS        (DU_BUS),
      .DAC_OUT       (DAC_OUT),
      .PHASE         (PHASE),
      .SAMPLE_REQ    (SAMPLE_REQ),
      .SAMPLE_ACK    (SAMPLE_ACK),
      .SAMPLE_TAG    (SAMPLE_TAG),
      .BUSY          (BUSY),
      .DONE          (DONE)
   );

   assign dac0 = DAC_OUT[DW-1:0];
   assign dac1 = DAC_OUT[2*DW-1:DW];

   always #5 CLK = ~CLK;

   always @(negedge CLK) if (DONE === 1'b1) done_cnt++;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_in(input int u0, input int du0, input int u1, input int du1);
      logic [DW-1:0] a, b, c, d;
      a = DW'(u0);
      b = DW'(du0);
      c = DW'(u1);
      d = DW'(du1);
      U_BUS  = {c, a};
      DU_BUS = {d, b};
   endtask

   task automatic add_vec(input logic [1:0] sel, input int u0, input int du0,
                          input int u1, input int du1, input int e0, input int e1);
      vec_t v;
      v.sel = sel;
      v.u0 = u0; v.du0 = du0; v.u1 = u1; v.du1 = du1;
      v.e0 = e0; v.e1 = e1;
      vecs.push_back(v);
   endtask

   task automatic wait_req(output int n);
      n = 0;
      while (SAMPLE_REQ !== 1'b1 && n < 50) begin
         tick;
         n++;
      end
   endtask

   // zero-settle, ACK-held sequence: one row per cycle after START
   logic [1:0] z_ph[6]   = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
   logic       z_req[6]  = '{0, 1, 0, 1, 0, 0};
   logic       z_tag[6]  = '{0, 1, 0, 0, 0, 0};
   logic       z_done[6] = '{0, 0, 0, 0, 1, 0};
   logic       z_busy[6] = '{1, 1, 1, 1, 1, 0};
   int         z_d0[6]   = '{8100, 8100, 7900, 7900, 8000, 8000};

   initial begin
      int n;
      int d0;
      int p0, p1;

      add_vec(2'b01, 8000, 100, 1000, -50, 8100, 950);
      add_vec(2'b10, 8000, 100, 1000, -50, 7900, 1050);
      add_vec(2'b11, 8000, 100, 1000, -50, 8000, 1000);
      add_vec(2'b00, 8000, 100, 1000, -50, 0, 0);
      add_vec(2'b01, 16380, 10, 5, -10, 16383, 0);
      add_vec(2'b10, 16380, 10, 5, -10, 16370, 15);
      add_vec(2'b10, 5, 10, 16380, -10, 0, 16383);
      add_vec(2'b01, 5, 10, 16380, -10, 15, 16370);
      add_vec(2'b01, 16383, -8192, 0, 8191, 8191, 8191);
      add_vec(2'b10, 16383, -8192, 0, 8191, 16383, 0);

      repeat (3) tick;
      check("rst_dac", DAC_OUT, 0);
      check("rst_phase", PHASE, 0);
      check("rst_req", SAMPLE_REQ, 0);
      check("rst_busy_done", {BUSY, DONE, SAMPLE_TAG}, 0);
      RST = 1'b0;
      tick;
      check("post_rst_dac", DAC_OUT, 0);

      // manual mode table
      p0 = 0;
      p1 = 0;
      foreach (vecs[i]) begin
         set_in(vecs[i].u0, vecs[i].du0, vecs[i].u1, vecs[i].du1);
         MAN_SEL = vecs[i].sel;
         #1;
         check($sformatf("man_hold%0d", i), {dac1, dac0}, {p1[DW-1:0], p0[DW-1:0]});
         tick;
         check($sformatf("man_ch0_%0d", i), dac0, vecs[i].e0);
         check($sformatf("man_ch1_%0d", i), dac1, vecs[i].e1);
         check($sformatf("man_ph%0d", i), PHASE, vecs[i].sel);
         p0 = vecs[i].e0;
         p1 = vecs[i].e1;
      end

      // START ignored in manual mode
      MAN_SEL = 2'b11;
      START = 1'b1;
      tick;
      START = 1'b0;
      check("man_start_busy", BUSY, 0);

      // auto sequence, settle 3, ACK two cycles after REQ
      MODE = 1'b1;
      MAN_SEL = 2'b00;
      SETTLE_CYCLES = 16'd3;
      set_in(8000, 100, 1000, -50);
      tick;
      d0 = done_cnt;
      START = 1'b1;
      tick;
      START = 1'b0;
      check("a_p0", dac0, 8100);
      check("a_p1", dac1, 950);
      check("a_ph", PHASE, 2'b01);
      check("a_busy", BUSY, 1);
      check("a_req", SAMPLE_REQ, 0);
      set_in(1, 2, 3, 4);
      MODE = 1'b0;
      wait_req(n);
      check("a_pset_len", n, 3);
      check("a_ptag", SAMPLE_TAG, 1);
      check("a_phold", dac0, 8100);
      tick;
      check("a_req_wait", SAMPLE_REQ, 1);
      SAMPLE_ACK = 1'b1;
      tick;
      SAMPLE_ACK = 1'b0;
      check("a_m0", dac0, 7900);
      check("a_m1", dac1, 1050);
      check("a_mph", PHASE, 2'b10);
      check("a_req_drop", SAMPLE_REQ, 0);
      START = 1'b1;
      tick;
      START = 1'b0;
      wait_req(n);
      check("a_mset_len", n + 1, 3);
      check("a_mtag", SAMPLE_TAG, 0);
      check("a_mph_busy_start", PHASE, 2'b10);
      check("a_mhold", dac0, 7900);
      tick;
      SAMPLE_ACK = 1'b1;
      tick;
      SAMPLE_ACK = 1'b0;
      check("a_u0", dac0, 8000);
      check("a_u1", dac1, 1000);
      check("a_uph", PHASE, 2'b11);
      check("a_done", DONE, 1);
      check("a_busy_restore", BUSY, 1);
      tick;
      MODE = 1'b1;
      check("a_done_end", DONE, 0);
      check("a_busy_end", BUSY, 0);
      check("a_idle_hold", dac0, 8000);
      check("a_done_cnt", done_cnt - d0, 1);

      // ABORT (with START) during M_SETTLE
      set_in(8000, 100, 1000, -50);
      START = 1'b1;
      tick;
      START = 1'b0;
      wait_req(n);
      SAMPLE_ACK = 1'b1;
      tick;
      SAMPLE_ACK = 1'b0;
      check("ab_pre", dac0, 7900);
      d0 = done_cnt;
      ABORT = 1'b1;
      START = 1'b1;
      tick;
      ABORT = 1'b0;
      START = 1'b0;
      check("ab_dac", DAC_OUT, 0);
      check("ab_ph", PHASE, 0);
      check("ab_busy", BUSY, 0);
      check("ab_req", SAMPLE_REQ, 0);
      repeat (5) tick;
      check("ab_no_done", done_cnt - d0, 0);
      check("ab_idle_dac", DAC_OUT, 0);

      // SETTLE_CYCLES=0 with ACK held high
      SETTLE_CYCLES = '0;
      SAMPLE_ACK = 1'b1;
      tick;
      d0 = done_cnt;
      START = 1'b1;
      tick;
      START = 1'b0;
      for (int t = 0; t < 6; t++) begin
         check($sformatf("z_ph%0d", t), PHASE, z_ph[t]);
         check($sformatf("z_req%0d", t), SAMPLE_REQ, z_req[t]);
         check($sformatf("z_tag%0d", t), SAMPLE_TAG, z_tag[t]);
         check($sformatf("z_done%0d", t), DONE, z_done[t]);
         check($sformatf("z_busy%0d", t), BUSY, z_busy[t]);
         check($sformatf("z_dac%0d", t), dac0, z_d0[t]);
         if (t < 5) tick;
      end
      SAMPLE_ACK = 1'b0;
      check("z_done_cnt", done_cnt - d0, 1);

      // async reset while in P_SAMPLE
      START = 1'b1;
      tick;
      START = 1'b0;
      tick;
      check("r_pre_req", SAMPLE_REQ, 1);
      RST = 1'b1;
      #1;
      check("r_dac", DAC_OUT, 0);
      check("r_ph", PHASE, 0);
      check("r_flags", {SAMPLE_REQ, SAMPLE_TAG, BUSY, DONE}, 0);
      tick;
      RST = 1'b0;
      tick;
      check("r_busy", BUSY, 0);
      check("r_idle_dac", DAC_OUT, 0);
      SAMPLE_ACK = 1'b1;
      tick;
      SAMPLE_ACK = 1'b0;
      check("r_ack_ignored", {SAMPLE_REQ, PHASE}, 0);
      START = 1'b1;
      tick;
      START = 1'b0;
      check("r_restart", dac0, 8100);
      check("r_restart_busy", BUSY, 1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/dac_phase_sequencer.md
Name: dac_phase_sequencer

Overview:
Clocked, N-channel successor to the combinational DAC output selector for the SPGD loop. In auto mode it runs one perturbation cycle per START: drive U+dU, settle, request a photodetector sample, drive U-dU, settle, request a second sample, then return to U. In manual mode it reproduces the legacy 2-bit select behaviour, but with registered outputs. It sits between the SPGD update core, which supplies U and dU, and the DAC interface; it handshakes with the ADC capture block.

Parameters:
DATA_WIDTH, 14, unsigned DAC code width per channel
NUM_CH, 2, number of DAC channels
SETTLE_W, 16, width of the settle-time counter

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
MODE  in  1  0 = manual (MAN_SEL), 1 = auto sequence; sampled only in IDLE
MAN_SEL  in  2  manual select: 11 = U, 01 = U+dU, 10 = U-dU, 00 = zero
START  in  1  single-cycle pulse; begins an auto sequence when in IDLE with MODE=1
ABORT  in  1  pulse; returns to IDLE from any state
SETTLE_CYCLES  in  SETTLE_W  DAC/optics settle time in CLK cycles
U_BUS  in  NUM_CH*DATA_WIDTH  unsigned control codes; channel k at [k*DATA_WIDTH +: DATA_WIDTH]
DU_BUS  in  NUM_CH*DATA_WIDTH  signed two's-complement perturbations, same packing
DAC_OUT  out  NUM_CH*DATA_WIDTH  registered DAC codes
PHASE  out  2  encoding of the currently driven value, same codes as MAN_SEL
SAMPLE_REQ  out  1  high while waiting for ADC capture
SAMPLE_ACK  in  1  ADC capture done
SAMPLE_TAG  out  1  1 = plus sample, 0 = minus sample; valid while SAMPLE_REQ is high
BUSY  out  1  high in any non-IDLE auto state
DONE  out  1  one-cycle pulse when a sequence completes

Behaviour:
- Reset values:
  - DAC_OUT = 0, PHASE = 00, SAMPLE_REQ = 0, SAMPLE_TAG = 0, BUSY = 0, DONE = 0.
  - FSM = IDLE; counter = 0; latched U/dU = 0.
- Arithmetic per channel:
  - P = U + dU and M = U - dU, computed at DATA_WIDTH+2 bits signed.
  - Results saturate to the range [0, 2^DATA_WIDTH-1].
- Manual mode (IDLE, MODE=0):
  - DAC_OUT and PHASE follow MAN_SEL and the live U_BUS/DU_BUS.
  - Latency is 1 cycle (registered).
  - START is ignored.
- Auto mode:
  - START in IDLE with MODE=1 latches U_BUS and DU_BUS. Live inputs are ignored until DONE, which gives coherent perturbations.
- FSM states:
  - IDLE: auto mode idles driving the last latched U (00 after reset).
  - P_SETTLE: drive P, PHASE=01. Counter loads SETTLE_CYCLES on entry and decrements each cycle. Leave when the counter reaches 0. SETTLE_CYCLES=0 gives exactly 1 cycle in P_SETTLE.
  - P_SAMPLE: SAMPLE_REQ=1, SAMPLE_TAG=1. On SAMPLE_ACK go to M_SETTLE. No timeout.
  - M_SETTLE: drive M, PHASE=10; same counting rule as P_SETTLE.
  - M_SAMPLE: SAMPLE_REQ=1, SAMPLE_TAG=0. On SAMPLE_ACK go to RESTORE.
  - RESTORE: drive latched U, PHASE=11. Pulse DONE for 1 cycle, then go to IDLE.
- Outputs change only on state transitions, so the DAC never sees a mixed-channel value.
- SAMPLE_REQ deasserts in the cycle after SAMPLE_ACK is seen. An ACK that arrives while SAMPLE_REQ is low is ignored.
- ABORT has priority over all other inputs. Next state is IDLE; DAC_OUT is driven to zero, PHASE=00, SAMPLE_REQ=0, no DONE pulse.
- START while BUSY is ignored.
- START and ABORT in the same cycle: ABORT wins.
- MODE changes while BUSY take effect only after returning to IDLE.
- Asserting RST mid-sequence immediately forces all reset values.

Decomposition:
- Package dac_seq_pkg holds:
  - the state enum/localparams;
  - the PHASE codes PH_ZERO=00, PH_PLUS=01, PH_MINUS=10, PH_U=11.
- Sub-module dac_sat_addsub, instantiated per channel by a generate loop:
  - combinational U±dU with saturation;
  - parameter DATA_WIDTH.

Test Plan:
- Reset: assert RST mid-P_SAMPLE -> all outputs zero immediately; after release, FSM is in IDLE and BUSY=0.
- Manual mode, DATA_WIDTH=14, U=8000, dU=100: MAN_SEL=01/10/11/00 -> DAC_OUT=8100/7900/8000/0, each one cycle after the select change.
- Auto mode, SETTLE_CYCLES=3, ACK two cycles after each REQ:
  - expect P=8100 held for 3 settle cycles, then SAMPLE_REQ with TAG=1;
  - then M=7900 with TAG=0;
  - then 8000 with a single DONE pulse;
  - input changes mid-sequence do not affect the output.
- Saturation: U=16380, dU=+10 -> P=16383; U=5, dU=+10 -> M=0; dU=-10 mirrors both cases.
- ABORT during M_SETTLE -> next cycle DAC_OUT=0, PHASE=00, no DONE; a later START runs a full sequence normally.
- Edge cases:
  - SETTLE_CYCLES=0 -> one cycle in each settle state.
  - SAMPLE_ACK held high continuously -> each sample state lasts exactly one cycle.
  - START while BUSY -> ignored.
